// File: rtl/serial_adder.sv
// Bit-serial add (and optional subtract) through one registered full-adder cell, LSB first.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the Sub port and borrow-style subtraction.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIn,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_bit;
    logic             a0;
    logic             b0;
    logic             s_bit;
    logic             c_next;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q;
`endif

    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // Single full-adder cell; with subtraction enabled the carry becomes a borrow.
    always_comb begin
        a0       = a_sh[0];
        b0       = b_sh[0];
        s_bit    = a0 ^ b0 ^ carry;
        c_next   = (a0 & b0) | (carry & (a0 ^ b0));
`ifdef SERIAL_ADDER_SUB_EN
        if (sub_q) begin
            c_next = (~a0 & b0) | (~(a0 ^ b0) & carry);
        end
`endif
        res_next = {s_bit, res_sh};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sum/Cout are written only on the completion edge so partial bits never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            res_sh <= '0;
            carry  <= CIn;
            cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q  <= Sub;
`endif
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next[WIDTH-1:1];
            carry  <= c_next;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                Sum  <= res_next;
                Cout <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, start handling, reset abort and random ops
// against an arithmetic reference model (subtract checks enabled with SERIAL_ADDER_SUB_EN).
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         CIn;
    logic         sub_sel;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] prev_sum  = '0;
    logic         prev_cout = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .CIn   (CIn),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub   (sub_sel),
`endif
        .Sum   (Sum),
        .Cout  (Cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {Cout,Sum} = A+B+CIn, or A-B-CIn with Cout = (A < B+CIn).
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        int unsigned ai, bi, ci;
        logic [W:0] r;
        ai = a;
        bi = b;
        ci = cin;
        if (sub) begin
            r[W-1:0] = W'(ai - bi - ci);
            r[W]     = (ai < bi + ci);
        end else begin
            r = (W + 1)'(ai + bi + ci);
        end
        return r;
    endfunction

    // Called right after a negedge while IDLE; returns 1ns after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        A     = a;
        B     = b;
        CIn   = cin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        CIn     = 1'b0;
        sub_sel = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (Sum !== '0) begin failures++; $display("[TB] FAIL reset_sum got=%h exp=00", Sum); end
        checks++;
        if (Cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout got=%b exp=0", Cout); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va[3] = '{8'h5A, 8'hFF, 8'h00};
        logic [W-1:0] vb[3] = '{8'h3C, 8'h01, 8'h00};
        logic         vc[3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] es[3] = '{8'h96, 8'h01, 8'h00};
        logic         ec[3] = '{1'b0, 1'b1, 1'b0};
        for (int v = 0; v < 3; v++) begin
            int busy_cnt = 0;
            int done_cnt = 0;
            int done_at  = -1;
            logic [W-1:0] got_sum = '0;
            logic         got_cout = 1'b0;
            sub_sel = 1'b0;
            launch(va[v], vb[v], vc[v]);
            for (int n = 1; n <= W + 2; n++) begin
                @(negedge clk);
                if (busy === 1'b1) busy_cnt++;
                if (done === 1'b1) begin done_cnt++; done_at = n; got_sum = Sum; got_cout = Cout; end
            end
            checks++;
            if (got_sum !== es[v]) begin
                failures++; $display("[TB] FAIL dir%0d_sum got=%h exp=%h", v, got_sum, es[v]);
            end
            checks++;
            if (got_cout !== ec[v]) begin
                failures++; $display("[TB] FAIL dir%0d_cout got=%b exp=%b", v, got_cout, ec[v]);
            end
            checks++;
            if (done_cnt != 1 || done_at != W + 1) begin
                failures++;
                $display("[TB] FAIL dir%0d_done pulses=%0d at=%0d exp 1 at %0d", v, done_cnt, done_at, W + 1);
            end
            checks++;
            if (busy_cnt != W + 1) begin
                failures++; $display("[TB] FAIL dir%0d_busy cycles=%0d exp=%0d", v, busy_cnt, W + 1);
            end
            prev_sum  = es[v];
            prev_cout = ec[v];
        end
    endtask

    task automatic test_start_ignored();
        logic [W:0] exp;
        logic [W:0] got = '0;
        int extra_busy = 0;
        sub_sel = 1'b0;
        exp = model(8'h21, 8'h43, 1'b1, 1'b0);
        launch(8'h21, 8'h43, 1'b1);
        for (int n = 1; n <= W + 4; n++) begin
            @(negedge clk);
            if (n == W + 1) got = {Cout, Sum};
            if (n > W + 1 && busy !== 1'b0) extra_busy++;
            if (n == 3 || n == 8) begin
                A = 8'hEE; B = 8'h77; CIn = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (got !== exp) begin
            failures++; $display("[TB] FAIL ignore_result got=%h exp=%h", got, exp);
        end
        checks++;
        if (extra_busy != 0) begin
            failures++; $display("[TB] FAIL ignore_no_accept busy_after=%0d exp=0", extra_busy);
        end
        prev_sum  = exp[W-1:0];
        prev_cout = exp[W];
    endtask

    task automatic test_back_to_back();
        localparam int P = W + 2;
        logic [W:0] exp1, exp2;
        logic [W:0] got1 = '0;
        logic [W:0] got2 = '0;
        int bad_busy = 0;
        int bad_done = 0;
        sub_sel = 1'b0;
        exp1 = model(8'h80, 8'h80, 1'b1, 1'b0);
        exp2 = model(8'h13, 8'h29, 1'b0, 1'b0);
        A = 8'h80; B = 8'h80; CIn = 1'b1; start = 1'b1;
        for (int n = 1; n <= 2 * P; n++) begin
            @(negedge clk);
            if (busy !== ((n == P || n == 2 * P) ? 1'b0 : 1'b1)) bad_busy++;
            if (done !== ((n == W + 1 || n == P + W + 1) ? 1'b1 : 1'b0)) bad_done++;
            if (n == W + 1) begin
                got1 = {Cout, Sum};
                A = 8'h13; B = 8'h29; CIn = 1'b0;
            end
            if (n == P + W + 1) got2 = {Cout, Sum};
        end
        start = 1'b0;
        checks++;
        if (got1 !== exp1) begin failures++; $display("[TB] FAIL held_res1 got=%h exp=%h", got1, exp1); end
        checks++;
        if (got2 !== exp2) begin failures++; $display("[TB] FAIL held_res2 got=%h exp=%h", got2, exp2); end
        checks++;
        if (bad_busy != 0) begin failures++; $display("[TB] FAIL held_busy bad_cycles=%0d exp=0", bad_busy); end
        checks++;
        if (bad_done != 0) begin failures++; $display("[TB] FAIL held_done bad_cycles=%0d exp=0", bad_done); end
        @(negedge clk);
        prev_sum  = exp2[W-1:0];
        prev_cout = exp2[W];
    endtask

    task automatic test_reset_abort();
        logic [W:0] exp;
        logic [W:0] got = '0;
        int stray = 0;
        sub_sel = 1'b0;
        launch(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, Cout, Sum} !== '0) begin
            failures++;
            $display("[TB] FAIL abort_outputs busy=%b done=%b cout=%b sum=%h exp all 0", busy, done, Cout, Sum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= W + 2; n++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || Sum !== '0 || Cout !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("[TB] FAIL abort_no_done bad_cycles=%0d exp=0", stray); end
        exp = model(8'hC3, 8'h5E, 1'b1, 1'b0);
        launch(8'hC3, 8'h5E, 1'b1);
        for (int n = 1; n <= W + 2; n++) begin
            @(negedge clk);
            if (n == W + 1) got = {Cout, Sum};
        end
        checks++;
        if (got !== exp) begin failures++; $display("[TB] FAIL abort_recover got=%h exp=%h", got, exp); end
        prev_sum  = exp[W-1:0];
        prev_cout = exp[W];
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [W:0] got = '0;
        sub_sel = 1'b1;
        launch(8'h10, 8'h20, 1'b0);
        for (int n = 1; n <= W + 2; n++) begin
            @(negedge clk);
            if (n == W + 1) got = {Cout, Sum};
        end
        checks++;
        if (got !== 9'h1F0) begin failures++; $display("[TB] FAIL sub1 got=%h exp=1f0", got); end
        launch(8'h50, 8'h20, 1'b1);
        for (int n = 1; n <= W + 2; n++) begin
            @(negedge clk);
            if (n == W + 1) got = {Cout, Sum};
        end
        checks++;
        if (got !== 9'h02F) begin failures++; $display("[TB] FAIL sub2 got=%h exp=02f", got); end
        sub_sel   = 1'b0;
        prev_sum  = 8'h2F;
        prev_cout = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int op = 0; op < 1000; op++) begin
            logic [W-1:0] a, b;
            logic cin;
            logic [W:0] exp;
            logic [W:0] got = '0;
            bit stable  = 1'b1;
            bit timing  = 1'b1;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
            sub_sel = 1'($urandom_range(0, 1));
`else
            sub_sel = 1'b0;
`endif
            exp = model(a, b, cin, sub_sel);
            launch(a, b, cin);
            for (int n = 1; n <= W + 2; n++) begin
                @(negedge clk);
                if (n <= W) begin
                    if (Sum !== prev_sum || Cout !== prev_cout) stable = 1'b0;
                    if (done !== 1'b0 || busy !== 1'b1) timing = 1'b0;
                end else if (n == W + 1) begin
                    got = {Cout, Sum};
                    if (done !== 1'b1 || busy !== 1'b1) timing = 1'b0;
                end else begin
                    if ({Cout, Sum} !== got) stable = 1'b0;
                    if (done !== 1'b0 || busy !== 1'b0) timing = 1'b0;
                end
            end
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL rand%0d_result a=%h b=%h cin=%b sub=%b got=%h exp=%h",
                         op, a, b, cin, sub_sel, got, exp);
            end
            checks++;
            if (!stable) begin
                failures++; $display("[TB] FAIL rand%0d_stable outputs moved outside completion, exp held", op);
            end
            checks++;
            if (!timing) begin
                failures++; $display("[TB] FAIL rand%0d_timing busy/done sequence wrong, exp done at %0d", op, W + 1);
            end
            prev_sum  = exp[W-1:0];
            prev_cout = exp[W];
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog time limit reached, exp run to finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
